// File: rtl/mult_div_unit.sv
// Multi-cycle signed MULT/DIV unit feeding HI/LO for the multicycle MIPS datapath.
// Radix-2 Booth multiply and restoring divide, one iteration per clock.
//
//   state  | meaning
//   IDLE   | waiting for start_mult / start_div
//   MULT   | Booth iterations on {acc, mq, qm1}
//   DIV    | restoring iterations on |A| / |B|
//   FINISH | sign fix-up, write HI/LO, pulse done
module mult_div_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_mult,
    input  logic                  start_div,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic [DATA_WIDTH-1:0] hi,
    output logic [DATA_WIDTH-1:0] lo,
    output logic                  busy,
    output logic                  done,
    output logic                  div_zero
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, MULT, DIV, FINISH} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [W-1:0]  acc, mq, m;
    logic          qm1, is_div, neg_q, neg_r;

    logic          last_iter, b_zero;
    logic [W-1:0]  abs_a, abs_b;
    logic [W:0]    booth_sum, rem_shift, rem_diff;
    logic          rem_ge;

    assign last_iter = (cnt == CW'(1));
    assign b_zero    = (op_b == '0);
    assign abs_a     = op_a[W-1] ? -op_a : op_a;
    assign abs_b     = op_b[W-1] ? -op_b : op_b;

    // One bit of headroom: subtracting the most negative multiplicand overflows W bits.
    always_comb begin
        booth_sum = {acc[W-1], acc};
        case ({mq[0], qm1})
            2'b01:   booth_sum = {acc[W-1], acc} + {m[W-1], m};
            2'b10:   booth_sum = {acc[W-1], acc} - {m[W-1], m};
            default: booth_sum = {acc[W-1], acc};
        endcase
    end

    // Partial remainder stays below the divisor, so the shifted value never reaches bit W.
    assign rem_shift = {acc, mq[W-1]};
    assign rem_diff  = rem_shift - {1'b0, m};
    assign rem_ge    = ~rem_diff[W];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start_mult)                 state_next = MULT;
                else if (start_div && !b_zero)  state_next = DIV;
            end
            MULT:    if (last_iter) state_next = FINISH;
            DIV:     if (last_iter) state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            acc      <= '0;
            mq       <= '0;
            m        <= '0;
            qm1      <= 1'b0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    cnt <= CW'(DATA_WIDTH);
                    if (start_mult) begin
                        acc    <= '0;
                        mq     <= op_b;
                        m      <= op_a;
                        qm1    <= 1'b0;
                        is_div <= 1'b0;
                        busy   <= 1'b1;
                    end else if (start_div) begin
                        if (b_zero) begin
                            div_zero <= 1'b1;
                        end else begin
                            acc    <= '0;
                            mq     <= abs_a;
                            m      <= abs_b;
                            is_div <= 1'b1;
                            neg_q  <= op_a[W-1] ^ op_b[W-1];
                            neg_r  <= op_a[W-1];
                            busy   <= 1'b1;
                        end
                    end
                end
                MULT: begin
                    acc <= booth_sum[W:1];
                    mq  <= {booth_sum[0], mq[W-1:1]};
                    qm1 <= mq[0];
                    cnt <= cnt - CW'(1);
                end
                DIV: begin
                    acc <= rem_ge ? rem_diff[W-1:0] : rem_shift[W-1:0];
                    mq  <= {mq[W-2:0], rem_ge};
                    cnt <= cnt - CW'(1);
                end
                FINISH: begin
                    if (is_div) begin
                        hi <= neg_r ? -acc : acc;
                        lo <= neg_q ? -mq : mq;
                    end else begin
                        hi <= acc;
                        lo <= mq;
                    end
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus randomized ops
// against a longint arithmetic reference.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_mult, start_div;
    logic [31:0] op_a, op_b;
    logic [31:0] hi, lo;
    logic        busy, done, div_zero;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;

    mult_div_unit #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .op_a       (op_a),
        .op_b       (op_b),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: signed arithmetic in 64 bits, division truncates toward zero.
    task automatic ref_model(input bit is_mult, input logic [31:0] a, input logic [31:0] b);
        longint la, lb, lq, lr, lp;
        la = longint'($signed(a));
        lb = longint'($signed(b));
        if (is_mult) begin
            lp     = la * lb;
            exp_hi = lp[63:32];
            exp_lo = lp[31:0];
        end else begin
            lq     = la / lb;
            lr     = la - lq * lb;
            exp_lo = lq[31:0];
            exp_hi = lr[31:0];
        end
    endtask

    // now=1 applies start on the current negedge (used for back-to-back on the done cycle).
    // poke=1 re-pulses both starts with junk operands at t0+10.
    task automatic do_op(input string tag, input bit sm, input bit sd,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit now, input bit poke);
        int cyc;
        if (!now) @(negedge clk);
        start_mult = sm;
        start_div  = sd;
        op_a       = a;
        op_b       = b;
        @(negedge clk);
        start_mult = 1'b0;
        start_div  = 1'b0;
        op_a       = $urandom;
        op_b       = $urandom;
        if (!sm && sd && b == 32'd0) begin
            chk({tag, ":div_zero"}, 64'(div_zero), 64'd1);
            chk({tag, ":dz_busy"},  64'(busy),     64'd0);
            chk({tag, ":dz_done"},  64'(done),     64'd0);
            chk({tag, ":dz_hi"},    64'(hi),       64'(exp_hi));
            chk({tag, ":dz_lo"},    64'(lo),       64'(exp_lo));
            @(negedge clk);
            chk({tag, ":dz_clear"}, 64'({div_zero, busy, done}), 64'd0);
        end else begin
            ref_model(sm, a, b);
            cyc = 0;
            while (busy && cyc < 100) begin
                if (poke && cyc == 9) begin
                    start_mult = 1'b1;
                    start_div  = 1'b1;
                    op_a       = $urandom;
                    op_b       = $urandom;
                end else begin
                    start_mult = 1'b0;
                    start_div  = 1'b0;
                end
                cyc++;
                @(negedge clk);
            end
            start_mult = 1'b0;
            start_div  = 1'b0;
            chk({tag, ":latency"}, 64'(cyc),  64'd33);
            chk({tag, ":done"},    64'(done), 64'd1);
            chk({tag, ":hi"},      64'(hi),   64'(exp_hi));
            chk({tag, ":lo"},      64'(lo),   64'(exp_lo));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ndone;
        logic [31:0] ra, rb;
        bit rm, rd;

        reset      = 1'b1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        op_a       = '0;
        op_b       = '0;
        repeat (3) @(negedge clk);
        chk("rst_hi",  64'(hi), 64'd0);
        chk("rst_lo",  64'(lo), 64'd0);
        chk("rst_flags", 64'({busy, done, div_zero}), 64'd0);
        reset = 1'b0;

        do_op("mul_mixed",  1, 0, 32'd7,          32'hFFFF_FFFD, 0, 0);
        do_op("mul_maxpos", 1, 0, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 0, 0);
        do_op("mul_min",    1, 0, 32'h8000_0000,  32'h8000_0000, 0, 0);
        do_op("div_neg_a",  0, 1, 32'hFFFF_FFF9,  32'd2,         0, 0);
        do_op("div_neg_b",  0, 1, 32'd7,          32'hFFFF_FFFE, 0, 0);
        do_op("div_ovf",    0, 1, 32'h8000_0000,  32'hFFFF_FFFF, 0, 0);
        do_op("preload",    1, 0, 32'h1234_5678,  32'h9ABC_DEF0, 0, 0);
        do_op("div_by_0",   0, 1, 32'h0000_1234,  32'd0,         0, 0);
        do_op("restart_ign",1, 0, 32'hFFFF_0001,  32'd12345,     0, 1);
        do_op("both_start", 1, 1, 32'd1000,       32'hFFFF_FFF6, 0, 0);
        do_op("b2b_first",  0, 1, 32'd100,        32'd7,         0, 0);
        do_op("b2b_second", 1, 0, 32'hDEAD_BEEF,  32'h0000_0013, 1, 0);

        // Reset in the middle of a multiply: results clear, no done follows.
        @(negedge clk);
        start_mult = 1'b1;
        op_a       = 32'd55;
        op_b       = 32'd66;
        @(negedge clk);
        start_mult = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        exp_hi = '0;
        exp_lo = '0;
        chk("midrst_hi",   64'(hi),   64'd0);
        chk("midrst_lo",   64'(lo),   64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midrst_nodone", 64'(ndone), 64'd0);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            rm = ($urandom_range(0, 1) == 1);
            rd = !rm || ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 5))
                0: rb = $urandom_range(1, 9);
                1: rb = -$urandom_range(1, 9);
                2: rb = 32'd0;
                3: ra = $urandom_range(0, 50);
                default: ;
            endcase
            do_op($sformatf("rnd%0d", i), rm, rd, ra, rb,
                  done ? bit'($urandom_range(0, 1)) : 1'b0, 0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
